// File: rtl/aes128_pkg.sv
// aes128_pkg: shared types and constants for the AES-128 CBC decrypt feeder.
//   feeder_state_e    : feeder FSM states (IDLE/COLLECT/WAIT/EMIT)
//   AES_BLK_W         : AES block width in bits
//   AES_WORD_W        : stream word width in bits
//   AES_WORDS_PER_BLK : stream words per AES block
package aes128_pkg;

  localparam int unsigned AES_BLK_W         = 128;
  localparam int unsigned AES_WORD_W        = 32;
  localparam int unsigned AES_WORDS_PER_BLK = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WAIT    = 2'd2,
    EMIT    = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/aes128_word_serializer.sv
// aes128_word_serializer: holds one decrypted 128-bit block and streams it
// out as four 32-bit words (word 0 first) with a valid/ready handshake.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_load     : capture i_block and start emitting
//   i_block    : block to emit; bits [31:0] go out first
//   i_last     : block is the last of the message (marks word 3)
//   i_ready    : downstream ready
//   o_valid    : word valid
//   o_data     : current word
//   o_last     : last word of message
//   o_done     : final word of the block accepted this cycle
module aes128_word_serializer
  import aes128_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [AES_BLK_W-1:0]  i_block,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [AES_WORD_W-1:0] o_data,
  output logic                  o_last,
  output logic                  o_done
);

  logic [AES_WORDS_PER_BLK-1:0][AES_WORD_W-1:0] r_buf;
  logic [1:0]                                   r_ecnt;
  logic                                         r_valid;
  logic                                         w_beat;

  assign w_beat  = r_valid && i_ready;
  assign o_done  = w_beat && (r_ecnt == 2'd3);
  assign o_valid = r_valid;
  assign o_data  = r_buf[r_ecnt];
  assign o_last  = r_valid && i_last && (r_ecnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf   <= '0;
      r_ecnt  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_buf   <= i_block;
      r_ecnt  <= '0;
      r_valid <= 1'b1;
    end else if (w_beat) begin
      r_ecnt <= r_ecnt + 2'd1;
      if (r_ecnt == 2'd3) r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aes128_cbc_dec_feeder.sv
// aes128_cbc_dec_feeder: stream adapter around a fixed-latency AES-128 CBC
// decryptor core. Packs 32-bit ciphertext words into blocks, drives the core,
// waits DEC_LATENCY cycles, then streams the plaintext out 32 bits at a time.
// CBC chaining: vector for block n is ciphertext block n-1; block 0 uses IV.
// Optional build macro AES_CBC_FEEDER_BLKCNT_EN adds a 16-bit blk_count output
// counting emitted blocks (cleared by reset and by an accepted iv_load).
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   iv_load, iv_in           : latch IV (accepted only in IDLE)
//   s_valid/s_ready/s_data/s_last : ciphertext word stream in
//   cipher_text_0..3, vector_0..3 : to core
//   plain_0..3               : from core decrypted_plain_text_0..3
//   m_valid/m_ready/m_data/m_last : plaintext word stream out
//   err                      : sticky framing error (s_last mid-block)
module aes128_cbc_dec_feeder
  import aes128_pkg::*;
#(
  parameter int unsigned DEC_LATENCY = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iv_load,
  input  logic [AES_BLK_W-1:0]  iv_in,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [AES_WORD_W-1:0] s_data,
  input  logic                  s_last,
  output logic [AES_WORD_W-1:0] cipher_text_0,
  output logic [AES_WORD_W-1:0] cipher_text_1,
  output logic [AES_WORD_W-1:0] cipher_text_2,
  output logic [AES_WORD_W-1:0] cipher_text_3,
  output logic [AES_WORD_W-1:0] vector_0,
  output logic [AES_WORD_W-1:0] vector_1,
  output logic [AES_WORD_W-1:0] vector_2,
  output logic [AES_WORD_W-1:0] vector_3,
  input  logic [AES_WORD_W-1:0] plain_0,
  input  logic [AES_WORD_W-1:0] plain_1,
  input  logic [AES_WORD_W-1:0] plain_2,
  input  logic [AES_WORD_W-1:0] plain_3,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [AES_WORD_W-1:0] m_data,
  output logic                  m_last,
  output logic                  err
`ifdef AES_CBC_FEEDER_BLKCNT_EN
  ,
  output logic [15:0]           blk_count
`endif
);

  feeder_state_e                                r_state, w_next;
  logic [AES_WORDS_PER_BLK-1:0][AES_WORD_W-1:0] r_ct, r_vec;
  logic [1:0]                                   r_wcnt;
  logic [7:0]                                   r_lat;
  logic                                         r_last_flag;
  logic                                         r_err;
  logic                                         w_beat, w_lat_done, w_ser_done;

  assign w_beat = s_valid && s_ready;

  assign cipher_text_0 = r_ct[0];
  assign cipher_text_1 = r_ct[1];
  assign cipher_text_2 = r_ct[2];
  assign cipher_text_3 = r_ct[3];
  assign vector_0      = r_vec[0];
  assign vector_1      = r_vec[1];
  assign vector_2      = r_vec[2];
  assign vector_3      = r_vec[3];
  assign err           = r_err;

  always_comb begin
    w_next     = r_state;
    s_ready    = 1'b0;
    w_lat_done = 1'b0;
    case (r_state)
      IDLE: if (iv_load) w_next = COLLECT;
      COLLECT: begin
        s_ready = 1'b1;
        if (w_beat) begin
          if (s_last && r_wcnt != 2'd3) w_next = IDLE;
          else if (r_wcnt == 2'd3)      w_next = WAIT;
        end
      end
      WAIT: begin
        // counter is about to reach zero: core output is valid this cycle
        if (r_lat == 8'd1) begin
          w_lat_done = 1'b1;
          w_next     = EMIT;
        end
      end
      EMIT: if (w_ser_done) w_next = r_last_flag ? IDLE : COLLECT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ct        <= '0;
      r_vec       <= '0;
      r_wcnt      <= '0;
      r_lat       <= '0;
      r_last_flag <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (iv_load) begin
            r_vec <= iv_in;
            r_err <= 1'b0;
          end
        end
        COLLECT: begin
          if (w_beat) begin
            if (s_last && r_wcnt != 2'd3) begin
              r_err  <= 1'b1;
              r_wcnt <= '0;
            end else begin
              r_ct[r_wcnt] <= s_data;
              r_wcnt       <= r_wcnt + 2'd1;
              if (r_wcnt == 2'd3) begin
                r_last_flag <= s_last;
                r_lat       <= 8'(DEC_LATENCY);
              end
            end
          end
        end
        WAIT: begin
          r_lat <= r_lat - 8'd1;
          if (w_lat_done) r_vec <= r_ct;
        end
        default: ;
      endcase
    end
  end

  aes128_word_serializer u_ser (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_lat_done),
    .i_block ({plain_3, plain_2, plain_1, plain_0}),
    .i_last  (r_last_flag),
    .i_ready (m_ready),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_last  (m_last),
    .o_done  (w_ser_done)
  );

`ifdef AES_CBC_FEEDER_BLKCNT_EN
  logic [15:0] r_blk_count;
  assign blk_count = r_blk_count;

  always_ff @(posedge clk) begin
    if (reset)                              r_blk_count <= '0;
    else if (r_state == IDLE && iv_load)    r_blk_count <= '0;
    else if (w_ser_done)                    r_blk_count <= r_blk_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_aes128_cbc_dec_feeder.sv
// Testbench for aes128_cbc_dec_feeder. The decryptor core is replaced by a
// behavioural stand-in: plain = D(cipher) ^ vector, where D reproduces the
// NIST SP800-38A CBC-AES128 vectors for the two known ciphertext blocks and is
// an arbitrary fixed mixing function otherwise. Core latency is checked by
// timing the gap between the last ciphertext beat and the first output word.
module tb_aes128_cbc_dec_feeder;
  localparam int unsigned LAT = 20;

  localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  logic        clk = 1'b0;
  logic        reset, iv_load, s_valid, s_last, m_ready;
  logic [127:0] iv_in;
  logic [31:0] s_data;
  logic        s_ready, m_valid, m_last, err;
  logic [31:0] m_data;
  logic [31:0] ct0, ct1, ct2, ct3, v0, v1, v2, v3;
  logic [127:0] w_ct, w_vec, w_plain;
`ifdef AES_CBC_FEEDER_BLKCNT_EN
  logic [15:0] blk_count;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [127:0] dmodel(input logic [127:0] c);
    if (c == C1) return P1 ^ IV;
    if (c == C2) return P2 ^ C1;
    return {c[60:0], c[127:61]} ^ 128'hA5C3_0F96_3C5A_F00F_1234_5678_9ABC_DEF0;
  endfunction

  assign w_ct    = {ct3, ct2, ct1, ct0};
  assign w_vec   = {v3, v2, v1, v0};
  assign w_plain = dmodel(w_ct) ^ w_vec;

  aes128_cbc_dec_feeder #(.DEC_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .iv_load(iv_load), .iv_in(iv_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cipher_text_0(ct0), .cipher_text_1(ct1), .cipher_text_2(ct2), .cipher_text_3(ct3),
    .vector_0(v0), .vector_1(v1), .vector_2(v2), .vector_3(v3),
    .plain_0(w_plain[31:0]), .plain_1(w_plain[63:32]),
    .plain_2(w_plain[95:64]), .plain_3(w_plain[127:96]),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err(err)
`ifdef AES_CBC_FEEDER_BLKCNT_EN
    , .blk_count(blk_count)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_iv(input logic [127:0] v);
    iv_in = v; iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int unsigned k = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && k < 100) begin tick(); k++; end
    chk("s_ready_wait", s_ready, 1);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Sends one block, pushes its expected plaintext, checks core-side inputs,
  // and optionally waits for the first output word to time the latency.
  task automatic send_block(input logic [127:0] c, input logic last,
                            input logic [127:0] pexp, input logic [127:0] vexp,
                            input bit wait_out);
    int unsigned k = 0;
    for (int unsigned w = 0; w < 4; w++) begin
      sb.push_back({(last && w == 3), pexp[32*w +: 32]});
      send_word(c[32*w +: 32], last && w == 3);
    end
    chk("wait_cipher", w_ct, c);
    chk("wait_vector", w_vec, vexp);
    chk("wait_s_ready", s_ready, 0);
    if (wait_out) begin
      while (!m_valid && k < LAT + 10) begin tick(); k++; end
      chk("latency", k, LAT);
    end
  endtask

  task automatic drain_block(input bit bp);
    logic [32:0] e;
    int unsigned k;
    for (int unsigned w = 0; w < 4; w++) begin
      k = 0;
      while (!m_valid && k < LAT + 10) begin tick(); k++; end
      chk("m_valid", m_valid, 1);
      chk("sb_nonempty", (sb.size() != 0), 1);
      e = (sb.size() != 0) ? sb.pop_front() : 33'h0;
      if (bp && w == 1) begin
        m_ready = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
          tick();
          chk("bp_valid", m_valid, 1);
          chk("bp_data", m_data, e[31:0]);
          chk("bp_s_ready", s_ready, 0);
        end
        m_ready = 1'b1;
      end
      chk("m_data", m_data, e[31:0]);
      chk("m_last", m_last, e[32]);
      tick();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ct"}, w_ct, 0);
    chk({tag, "_vec"}, w_vec, 0);
    chk({tag, "_ctl"}, {s_ready, m_valid, m_last, err}, 0);
    chk({tag, "_mdata"}, m_data, 0);
  endtask

  initial begin
    logic [127:0] c, pv;
    reset = 1'b1; iv_load = 1'b0; iv_in = '0; s_valid = 1'b0; s_data = '0;
    s_last = 1'b0; m_ready = 1'b1;
    tick(); tick();
    check_zero_outputs("reset");
    reset = 1'b0;
    tick();
    chk("idle_s_ready", s_ready, 0);

    // 1. single NIST block
    load_iv(IV);
    chk("collect_s_ready", s_ready, 1);
    send_block(C1, 1'b1, P1, IV, 1'b1);
    drain_block(1'b0);
    chk("end_idle", {s_ready, m_valid}, 0);

    // 2+3. two-block chaining with backpressure; stray iv_load ignored
    load_iv(IV);
    send_block(C1, 1'b0, P1, IV, 1'b1);
    drain_block(1'b1);
    load_iv(~IV);
    chk("ivload_ignored", w_vec, C1);
    send_block(C2, 1'b1, P2, C1, 1'b1);
    drain_block(1'b0);
    chk("sb_empty", sb.size(), 0);

    // 4. framing error: s_last on word 2
    load_iv(IV);
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    send_word(32'h3333_3333, 1'b1);
    chk("err_set", err, 1);
    chk("err_s_ready", s_ready, 0);
    tick();
    chk("err_sticky", err, 1);
    load_iv(IV);
    chk("err_cleared", err, 0);
    send_block(C1, 1'b1, P1, IV, 1'b1);
    drain_block(1'b0);

    // 5. reset mid-WAIT
    load_iv(IV);
    send_block(C2, 1'b1, 128'h0, IV, 1'b0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check_zero_outputs("midrst");
    reset = 1'b0;
    sb.delete();
    repeat (LAT + 5) tick();
    chk("midrst_no_out", m_valid, 0);
    load_iv(IV);
    send_block(C1, 1'b1, P1, IV, 1'b1);
    drain_block(1'b0);

    // three pseudo-random chained blocks
    load_iv(IV);
    pv = IV;
    for (int unsigned b = 0; b < 3; b++) begin
      c = {$urandom, $urandom, $urandom, $urandom};
      send_block(c, b == 2, dmodel(c) ^ pv, pv, 1'b1);
      drain_block(b == 1);
      pv = c;
    end
    chk("rand_sb_empty", sb.size(), 0);

`ifdef AES_CBC_FEEDER_BLKCNT_EN
    // 6. block counter
    chk("blkcnt_3", blk_count, 3);
    load_iv(IV);
    chk("blkcnt_clr", blk_count, 0);
    force dut.r_blk_count = 16'hFFFF;
    #1;
    release dut.r_blk_count;
    chk("blkcnt_forced", blk_count, 16'hFFFF);
    send_block(C1, 1'b1, P1, IV, 1'b1);
    drain_block(1'b0);
    chk("blkcnt_wrap", blk_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/aes128_cbc_dec_feeder.md
Name: aes128_cbc_dec_feeder

Overview:
Upstream/downstream stream adapter for the AES-128 CBC decryptor core. It assembles a 32-bit ciphertext word stream into 128-bit blocks and drives the core's cipher_text_0..3 and vector_0..3 inputs. It waits the core's fixed pipeline latency, captures decrypted_plain_text_0..3, and streams them out as 32-bit words. It also owns CBC chaining: the vector for block n is ciphertext block n-1, and the vector for block 0 is the loaded IV.

Parameters:
DEC_LATENCY, 20, cycles from cipher_text/vector stable to valid decrypted_plain_text at the core (1..255).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
iv_load  in  1  one-cycle pulse: latch iv_in as the chaining vector.
iv_in  in  128  initial vector; bits [31:0] map to vector_0.
s_valid  in  1  ciphertext word valid.
s_ready  out  1  feeder accepts a ciphertext word.
s_data  in  32  ciphertext word; the first word of a block maps to cipher_text_0.
s_last  in  1  last word of message.
cipher_text_0..3  out  32 each  to decryptor core.
vector_0..3  out  32 each  to decryptor core.
plain_0..3  in  32 each  from the core's decrypted_plain_text_0..3.
m_valid  out  1  plaintext word valid.
m_ready  in  1  downstream accepts a word.
m_data  out  32  plaintext word, plain_0 first.
m_last  out  1  last word of message.
err  out  1  sticky framing error.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state = IDLE; s_ready, m_valid, m_last, err = 0.
  - cipher_text_*, vector_*, m_data = 0.
  - Word counter = 0; latency counter = 0; last_flag = 0.
- States: IDLE, COLLECT, WAIT, EMIT.
- IDLE:
  - s_ready = 0.
  - On iv_load, load vector_3..0 from iv_in, clear err, and go to COLLECT.
- COLLECT:
  - s_ready = 1.
  - Each s_valid&&s_ready beat writes s_data into cipher_text_[wcnt] and increments wcnt (2 bits).
  - The beat with wcnt==3 latches s_last into last_flag, loads the latency counter with DEC_LATENCY, and goes to WAIT.
  - s_last on a beat with wcnt!=3: set err, discard the partial block, reset wcnt, go to IDLE. A new iv_load is required.
- WAIT:
  - s_ready = 0; cipher_text_* and vector_* are held stable.
  - Decrement the latency counter. When it reaches 0, go to EMIT.
  - In that same cycle, latch plain_0..3 into the output buffer and copy vector_* <= cipher_text_* (CBC chaining).
- EMIT:
  - m_valid = 1; m_data = buffer[ecnt].
  - m_last = last_flag && ecnt==3.
  - ecnt advances only on m_valid&&m_ready. m_valid stays high and m_data stays stable while m_ready is low.
  - After the beat with ecnt==3: go to IDLE if last_flag is set, otherwise go to COLLECT.
- iv_load outside IDLE is ignored. Mid-message IV change is not supported.
- With DEC_LATENCY=1, WAIT lasts exactly one cycle.
- Reset asserted in any state returns all registers to reset values on the next edge. No partial output follows.
- Throughput: one block per 4 + DEC_LATENCY + 4 cycles minimum (no overlap).

Optional Feature:
- Macro: AES_CBC_FEEDER_BLKCNT_EN.
- With the macro defined:
  - Adds output port blk_count, 16 bits.
  - blk_count increments on the final EMIT beat of each block.
  - It clears to 0 on reset and on an accepted iv_load.
  - It wraps from 0xFFFF to 0x0000.
- Without the macro: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package aes128_pkg holds:
  - State encoding localparams: IDLE=2'd0, COLLECT=2'd1, WAIT=2'd2, EMIT=2'd3.
  - AES_BLK_W=128 and AES_WORD_W=32.
  - Words-per-block constant = 4.
- One natural sub-module, aes128_word_serializer: the 4x32 EMIT buffer with its valid/ready handshake.
- The FSM, collector and chaining registers stay in the top module.

Test Plan:
All scenarios connect the real decryptor core, key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102030405060708090a0b0c0d0e0f. In every 128-bit value written as hex, word 3 is the leftmost.
1. Single block: iv_load, then 4 words of 7649abac8119b246cee98e9b12e9197d with s_last on word 3 -> m_data words of 6bc1bee22e409f96e93d7e117393172a; m_last on word 3; FSM returns to IDLE.
2. Two-block chaining: second block 5086cb9b507219ee95db113a917678b2 -> plaintext ae2d8a571e03ac9c9eb76fac45af8e51; vector_* equals the first ciphertext during the second WAIT.
3. Backpressure: hold m_ready=0 for 10 cycles mid-EMIT -> m_data and m_valid are stable, no word is lost or duplicated, s_ready stays 0 throughout.
4. Framing error: s_last on word 2 -> err=1, return to IDLE, s_ready=0; a following iv_load clears err.
5. Reset mid-WAIT: assert reset for 1 cycle -> all outputs 0 on the next edge; a fresh single-block run then passes.
6. With AES_CBC_FEEDER_BLKCNT_EN: run 3 blocks -> blk_count=3; iv_load -> blk_count=0; force the counter to 0xFFFF and run 1 block -> blk_count=0.
